seq_alu: RTL and testbench

Parametrised, registered ALU for the MIPS datapath. It keeps the existing 4-bit aluop encoding (ADD through JMEM) and adds iterative multiply, unsigned divide and remainder behind a start/busy/done handshake. Single-cycle ops complete one clock after acceptance; multi-cycle ops stall the pipeline via `busy`. It sits between the ALU control block and the EX/MEM register and replaces the combinational ALU once MUL/DIV instructions are enabled.

---
 rtl/seq_alu.sv | 162 ++++++++++++++++
 tb/tb_seq_alu.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered ALU: single-cycle ops plus iterative MUL / DIVU / REMU
// behind a start/busy/done handshake. Divider present only when
// SEQ_ALU_DIV_EN is defined.
// Ports: clk, rst (async, active-high), start, a, b, aluop in;
//        busy, done, result, zeros, ovf out.
module seq_alu #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluop,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zeros,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_n;

  // opa: multiplicand, or dividend/quotient shift register
  // opb: multiplier shift register, or divisor
  // acc: product accumulator, or partial remainder
  logic [WIDTH-1:0] opa, opb, acc;
  logic [3:0]       op;
  logic [CW-1:0]    cnt;

  logic             is_slow;
  logic [WIDTH-1:0] sum, dif, fast_res;
  logic             fast_ovf;
  logic [WIDTH-1:0] it_opa, it_opb, it_acc, slow_res;
  logic             last;
`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0]   sh, diff;
`endif

  always_comb begin
    is_slow = (aluop == 4'b1101);
`ifdef SEQ_ALU_DIV_EN
    is_slow = is_slow || (aluop == 4'b1110) || (aluop == 4'b1111);
`endif
  end

  assign sum = a + b;
  assign dif = a - b;

  always_comb begin
    fast_res = '0;
    fast_ovf = 1'b0;
    unique case (aluop)
      4'b0001, 4'b0110: begin
        fast_res = sum;
        fast_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                   (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b1000, 4'b1001, 4'b1010, 4'b1100: fast_res = sum;
      4'b0010: begin
        fast_res = dif;
        fast_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                   (dif[WIDTH-1] != a[WIDTH-1]);
      end
      4'b1011:          fast_res = dif;
      4'b0011, 4'b0111: fast_res = a & b;
      4'b0100:          fast_res = a | b;
      4'b0101:          fast_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default:          fast_res = '0;
    endcase
  end

  // One iteration of the active slow op.
  always_comb begin
    it_acc   = acc + (opb[0] ? opa : '0);
    it_opa   = opa << 1;
    it_opb   = opb >> 1;
    slow_res = it_acc;
`ifdef SEQ_ALU_DIV_EN
    sh   = {acc, opa[WIDTH-1]};
    diff = sh - {1'b0, opb};
    if (op[1]) begin
      it_opb = opb;
      // Restoring step; a zero divisor always "fits", which yields
      // an all-ones quotient and the dividend as remainder.
      if (!diff[WIDTH]) begin
        it_acc = diff[WIDTH-1:0];
        it_opa = {opa[WIDTH-2:0], 1'b1};
      end else begin
        it_acc = sh[WIDTH-1:0];
        it_opa = {opa[WIDTH-2:0], 1'b0};
      end
      slow_res = op[0] ? it_acc : it_opa;
    end
`endif
  end

  assign last = (cnt == CW'(1));
  assign busy = (state == RUN);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start && is_slow) state_n = RUN;
      RUN:  if (last)             state_n = IDLE;
      default:                    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      op     <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
      zeros  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (is_slow) begin
            opa <= a;
            opb <= b;
            acc <= '0;
            op  <= aluop;
            cnt <= CW'(WIDTH);
          end else begin
            result <= fast_res;
            zeros  <= (fast_res == '0);
            ovf    <= fast_ovf;
            done   <= 1'b1;
          end
        end
      end else begin
        opa <= it_opa;
        opb <= it_opb;
        acc <= it_acc;
        cnt <= cnt - CW'(1);
        if (last) begin
          result <= slow_res;
          zeros  <= (slow_res == '0);
          ovf    <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=20), scoreboard based.
// Honours SEQ_ALU_DIV_EN for divider expectations.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [19:0] a, b;
  logic [3:0]  aluop;
  logic        busy, done, zeros, ovf;
  logic [19:0] result;

  seq_alu #(.WIDTH(20)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .aluop(aluop),
    .busy(busy), .done(done), .result(result),
    .zeros(zeros), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] r;
    logic        z;
    logic        v;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [19:0] x);
    return x[19] ? longint'(x) - (longint'(1) << 20) : longint'(x);
  endfunction

  function automatic bit slow_op(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
    return op >= 4'd13;
`else
    return op == 4'd13;
`endif
  endfunction

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [19:0] x, y);
    exp_t   e;
    longint f;
    logic [39:0] p;
    e.r = '0;
    e.v = 1'b0;
    case (op)
      4'd1, 4'd6: begin
        e.r = x + y;
        f = sx(x) + sx(y);
        e.v = (f > 524287) || (f < -524288);
      end
      4'd8, 4'd9, 4'd10, 4'd12: e.r = x + y;
      4'd2: begin
        e.r = x - y;
        f = sx(x) - sx(y);
        e.v = (f > 524287) || (f < -524288);
      end
      4'd11:      e.r = x - y;
      4'd3, 4'd7: e.r = x & y;
      4'd4:       e.r = x | y;
      4'd5:       e.r = (x < y) ? 20'd1 : 20'd0;
      4'd13: begin
        p = 40'(x) * 40'(y);
        e.r = p[19:0];
      end
`ifdef SEQ_ALU_DIV_EN
      4'd14: e.r = (y == 0) ? 20'hFFFFF : x / y;
      4'd15: e.r = (y == 0) ? x : x % y;
`endif
      default: e.r = '0;
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction

  // Scoreboard check of every completion.
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.r);
        chk("zeros", zeros, e.z);
        chk("ovf", ovf, e.v);
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [19:0] x, y);
    start = 1'b1;
    aluop = op;
    a = x;
    b = y;
    sb.push_back(model(op, x, y));
  endtask

  task automatic run_op(input logic [3:0] op, input logic [19:0] x, y,
                        output int lat, output int bc);
    bit got;
    @(negedge clk);
    drive(op, x, y);
    lat = 0;
    bc = 0;
    got = 0;
    while (!got && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) start = 1'b0;
      if (done) got = 1;
      else if (busy) bc++;
    end
    if (!got) chk("timeout", 0, 1);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [19:0] x;
    logic [19:0] y;
  } vec_t;

  vec_t tbl[$] = '{
    '{4'd14, 20'h00064, 20'h00007},
    '{4'd15, 20'h00064, 20'h00007},
    '{4'd14, 20'h12345, 20'h00000},
    '{4'd15, 20'h12345, 20'h00000},
    '{4'd1,  20'h7FFFF, 20'h00001},
    '{4'd2,  20'h00000, 20'h80000},
    '{4'd11, 20'h00055, 20'h00055},
    '{4'd3,  20'hF0F0F, 20'h0FF00},
    '{4'd4,  20'hA0000, 20'h00005},
    '{4'd0,  20'h12345, 20'h00001},
    '{4'd5,  20'h00005, 20'h00003},
    '{4'd13, 20'hFFFFF, 20'hFFFFF},
    '{4'd13, 20'h00123, 20'h00045}
  };

  initial begin
    int  lat, bc, n;
    bit  got;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    aluop = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_zeros", zeros, 1);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(4'd1, 20'hFFFFF, 20'h00001, lat, bc);
    chk("add_lat", lat, 1);
    chk("add_busy", bc, 0);

    @(negedge clk);
    drive(4'd2, 20'h80000, 20'h00001);
    @(posedge clk);
    #1;
    chk("b2b_done1", done, 1);
    @(negedge clk);
    drive(4'd5, 20'h00003, 20'h00005);
    @(posedge clk);
    #1;
    chk("b2b_done2", done, 1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_done_end", done, 0);

    // MUL with a start pulse that must be ignored mid-RUN.
    @(negedge clk);
    drive(4'd13, 20'h00123, 20'h00045);
    n = 0;
    bc = 0;
    got = 0;
    while (!got && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) start = 1'b0;
      if (n == 5) begin
        start = 1'b1;
        aluop = 4'd1;
        a = 20'h1;
        b = 20'h1;
      end
      if (n == 6) start = 1'b0;
      if (done) got = 1;
      else if (busy) bc++;
    end
    chk("mul_lat", n, 21);
    chk("mul_busy", bc, 20);
    @(posedge clk);
    #1;
    chk("mul_done_pulse", done, 0);

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].x, tbl[i].y, lat, bc);
      chk("tbl_lat", lat, slow_op(tbl[i].op) ? 21 : 1);
      chk("tbl_busy", bc, slow_op(tbl[i].op) ? 20 : 0);
    end
    @(negedge clk);
    chk("prior_result", result, 20'h04E6F);

    // Reset five cycles into a MUL run.
    drive(4'd13, 20'h00321, 20'h00017);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_zeros", zeros, 1);
    chk("abort_done", done, 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    run_op(4'd1, 20'h00002, 20'h00003, lat, bc);
    chk("post_rst_lat", lat, 1);

    repeat (25) @(posedge clk);
    #2;
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
